// File: rtl/clk_div_sched_pkg.sv
// Shared types, defaults and sizing helpers for the clock-divider change scheduler.
package clk_div_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGate,
        StLoad,
        StSettle,
        StRelease
    } state_e;

    localparam int unsigned DEF_DIV_W       = 8;
    localparam int unsigned DEF_N_REQ       = 2;
    localparam int unsigned DEF_QUIESCE_CYC = 2;
    localparam int unsigned DEF_SETTLE_CYC  = 4;
    localparam int unsigned DEF_RESET_RATIO = 1;

    // Counter must hold the larger of the two phase lengths minus one, plus headroom.
    function automatic int unsigned cnt_width(input int unsigned q, input int unsigned s);
        int unsigned m;
        m = (q > s) ? q : s;
        return $clog2(m) + 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_sched_rr_arbiter.sv
// Round-robin arbiter: combinational grant from the pointer, pointer moves past each grant.
module rr_arbiter
    import clk_div_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_adv,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int unsigned      k;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = (int'(ptr_q) + i) % N_REQ;
            if (!found && i_req[k[IDX_W-1:0]]) begin
                found                 = 1'b1;
                o_gnt[k[IDX_W-1:0]]   = 1'b1;
                o_gnt_idx             = k[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else if (i_adv) begin
            ptr_q <= (int'(o_gnt_idx) == N_REQ - 1) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Sequences divide-ratio changes into ClkDiv: gate enable, load ratio, settle, re-enable, ack.
module clk_div_sched
    import clk_div_sched_pkg::*;
#(
    parameter int unsigned DIV_W       = DEF_DIV_W,
    parameter int unsigned N_REQ       = DEF_N_REQ,
    parameter int unsigned QUIESCE_CYC = DEF_QUIESCE_CYC,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned RESET_RATIO = DEF_RESET_RATIO
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*DIV_W-1:0] i_ratio,
    output logic [N_REQ-1:0]       o_ack,
    output logic                   o_err,
    output logic                   o_busy,
    output logic                   o_clk_en,
    output logic [DIV_W-1:0]       o_div_ratio
);

    localparam int unsigned CNT_W = cnt_width(QUIESCE_CYC, SETTLE_CYC);
    localparam int unsigned IDX_W = idx_width(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIV_W-1:0] ratio_lat_q;
    logic [IDX_W-1:0] idx_lat_q;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [DIV_W-1:0] gnt_ratio;

    // A requester still holding req in its ack cycle must not be re-granted.
    assign elig      = (state_q == StIdle) ? (i_req & ~o_ack) : '0;
    assign gnt_vld   = (state_q == StIdle) && (|gnt);
    assign gnt_ratio = i_ratio[int'(gnt_idx)*DIV_W +: DIV_W];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_ref_clk (i_ref_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (elig),
        .i_adv     (gnt_vld),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx)
    );

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ratio_lat_q <= '0;
            idx_lat_q   <= '0;
            o_ack       <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_clk_en    <= 1'b0;
            o_div_ratio <= DIV_W'(RESET_RATIO);
        end else begin
            o_ack <= '0;
            o_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    o_clk_en <= i_enable;
                    if (gnt_vld) begin
                        if (gnt_ratio == '0) begin
                            o_ack <= gnt;
                            o_err <= 1'b1;
                        end else if (gnt_ratio == o_div_ratio) begin
                            o_ack <= gnt;
                        end else begin
                            ratio_lat_q <= gnt_ratio;
                            idx_lat_q   <= gnt_idx;
                            o_clk_en    <= 1'b0;
                            o_busy      <= 1'b1;
                            cnt_q       <= CNT_W'(QUIESCE_CYC - 1);
                            state_q     <= StGate;
                        end
                    end
                end
                StGate: begin
                    o_clk_en <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= StLoad;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StLoad: begin
                    o_clk_en    <= 1'b0;
                    o_div_ratio <= ratio_lat_q;
                    cnt_q       <= CNT_W'(SETTLE_CYC - 1);
                    state_q     <= StSettle;
                end
                StSettle: begin
                    o_clk_en <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= StRelease;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StRelease: begin
                    o_ack    <= ONE_HOT0 << idx_lat_q;
                    o_busy   <= 1'b0;
                    o_clk_en <= i_enable;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed self-checking bench for clk_div_sched with default parameters.
module tb_clk_div_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  req;
    logic [15:0] ratio;
    logic [1:0]  ack;
    logic        err;
    logic        busy;
    logic        clk_en;
    logic [7:0]  div_ratio;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;
    logic en_seen;

    always #5 clk = ~clk;

    clk_div_sched dut (
        .i_ref_clk   (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_req       (req),
        .i_ratio     (ratio),
        .o_ack       (ack),
        .o_err       (err),
        .o_busy      (busy),
        .o_clk_en    (clk_en),
        .o_div_ratio (div_ratio)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until any ack appears (bounded); reports cycles taken and whether clk_en was seen high.
    task automatic wait_ack(output int n, output logic saw_en);
        n      = 0;
        saw_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (clk_en) saw_en = 1'b1;
            if (ack != 2'b00) break;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 2'b00;
        ratio  = 16'h0000;

        // 1: reset state, enable follows one cycle later
        tick();
        tick();
        chk("rst_clk_en", 32'(clk_en), 32'd0);
        chk("rst_ratio", 32'(div_ratio), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_clk_en", 32'(clk_en), 32'd1);

        // 2: req0 to ratio 8
        ratio[7:0] = 8'd8;
        req        = 2'b01;
        tick();
        chk("t2_busy_E", 32'(busy), 32'd1);
        chk("t2_clk_en_E", 32'(clk_en), 32'd0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk("t2_clk_en_gated", 32'(clk_en), 32'd0);
            chk("t2_ratio", 32'(div_ratio), (c >= 3) ? 32'd8 : 32'd1);
            chk("t2_no_ack", 32'(ack), 32'd0);
        end
        tick();
        chk("t2_ack_E8", 32'(ack), 32'd1);
        chk("t2_clk_en_E8", 32'(clk_en), 32'd1);
        chk("t2_busy_E8", 32'(busy), 32'd0);
        req = 2'b00;
        tick();
        chk("t2_ack_pulse", 32'(ack), 32'd0);

        // 3: simultaneous requests from pointer 0, twice
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        ratio = {8'd6, 8'd4};
        req   = 2'b11;
        tick();
        wait_ack(cyc, en_seen);
        chk("t3a_lat0", 32'(cyc), 32'd8);
        chk("t3a_ack0", 32'(ack), 32'b01);
        chk("t3a_ratio0", 32'(div_ratio), 32'd4);
        req = 2'b10;
        wait_ack(cyc, en_seen);
        chk("t3a_lat1", 32'(cyc), 32'd9);
        chk("t3a_ack1", 32'(ack), 32'b10);
        chk("t3a_ratio1", 32'(div_ratio), 32'd6);
        req = 2'b00;
        tick();
        ratio = {8'd7, 8'd3};
        req   = 2'b11;
        tick();
        wait_ack(cyc, en_seen);
        chk("t3b_lat0", 32'(cyc), 32'd8);
        chk("t3b_ack0", 32'(ack), 32'b01);
        chk("t3b_ratio0", 32'(div_ratio), 32'd3);
        req = 2'b10;
        wait_ack(cyc, en_seen);
        chk("t3b_lat1", 32'(cyc), 32'd9);
        chk("t3b_ack1", 32'(ack), 32'b10);
        chk("t3b_ratio1", 32'(div_ratio), 32'd7);
        req = 2'b00;
        tick();

        // 4: fast path (same ratio) then error path (ratio 0)
        ratio[15:8] = 8'd7;
        req         = 2'b10;
        tick();
        chk("t4_fast_ack", 32'(ack), 32'b10);
        chk("t4_fast_err", 32'(err), 32'd0);
        chk("t4_fast_clk_en", 32'(clk_en), 32'd1);
        chk("t4_fast_busy", 32'(busy), 32'd0);
        req = 2'b00;
        tick();
        chk("t4_fast_pulse", 32'(ack), 32'd0);
        chk("t4_fast_clk_en2", 32'(clk_en), 32'd1);
        ratio[15:8] = 8'd0;
        req         = 2'b10;
        tick();
        chk("t4_err_ack", 32'(ack), 32'b10);
        chk("t4_err_err", 32'(err), 32'd1);
        chk("t4_err_ratio", 32'(div_ratio), 32'd7);
        chk("t4_err_clk_en", 32'(clk_en), 32'd1);
        req = 2'b00;
        tick();
        chk("t4_err_pulse", 32'(err), 32'd0);

        // 5: reset during SETTLE, then re-issue
        ratio[7:0] = 8'd9;
        req        = 2'b01;
        tick();
        for (int c = 0; c < 4; c++) tick();
        chk("t5_ratio_loaded", 32'(div_ratio), 32'd9);
        chk("t5_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_ratio", 32'(div_ratio), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ack", 32'(ack), 32'd0);
        chk("t5_rst_clk_en", 32'(clk_en), 32'd0);
        rst_n = 1'b1;
        wait_ack(cyc, en_seen);
        chk("t5_reissue_lat", 32'(cyc), 32'd9);
        chk("t5_reissue_ack", 32'(ack), 32'b01);
        chk("t5_reissue_ratio", 32'(div_ratio), 32'd9);
        req = 2'b00;
        tick();

        // 6: change with enable low throughout
        enable = 1'b0;
        tick();
        chk("t6_en_drop", 32'(clk_en), 32'd0);
        ratio[7:0] = 8'd5;
        req        = 2'b01;
        tick();
        wait_ack(cyc, en_seen);
        chk("t6_lat", 32'(cyc), 32'd8);
        chk("t6_ack", 32'(ack), 32'b01);
        chk("t6_ratio", 32'(div_ratio), 32'd5);
        chk("t6_en_never", 32'(en_seen), 32'd0);
        req    = 2'b00;
        enable = 1'b1;
        tick();
        chk("t6_en_back", 32'(clk_en), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
